// File: rtl/uart_sha256_host_if.sv
// Bundle of the message stream, UART byte cores and job status signals around
// the SHA-256 host. The driver side sees "master", the host block sees "slave".
interface uart_sha256_host_if;
    logic         start;
    logic [7:0]   msg_data;
    logic         msg_valid;
    logic         msg_last;
    logic         msg_ready;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         busy;
    logic         done;
    logic [255:0] digest;
    logic [1:0]   err;
    logic         trunc;

    modport master (
        output start, msg_data, msg_valid, msg_last, tx_busy, rx_data, rx_valid,
        input  msg_ready, tx_start, tx_data, busy, done, digest, err, trunc
    );

    modport slave (
        input  start, msg_data, msg_valid, msg_last, tx_busy, rx_data, rx_valid,
        output msg_ready, tx_start, tx_data, busy, done, digest, err, trunc
    );
endinterface

// File: rtl/uart_sha256_host.sv
// Host-side job sequencer for the UART SHA-256 device: frames a message as
// START_BYTE <msg> TERM_BYTE towards the TX core, then gathers 64 ASCII hex
// digits from the RX core into a 256-bit digest.
module uart_sha256_host #(
    parameter logic [7:0]  START_BYTE     = 8'h01,
    parameter logic [7:0]  TERM_BYTE      = 8'hFF,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input logic                clk,
    input logic                rst_n,
    uart_sha256_host_if.slave  bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSendCmd,
        StSendMsg,
        StSendTerm,
        StRecv,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic            tx_start_q, tx_start_d;
    logic            guard_q;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [255:0]    digest_q, digest_d;
    logic [1:0]      err_q, err_d;
    logic            trunc_q, trunc_d;
    logic            term_sent_q, term_sent_d;
    logic [6:0]      nib_cnt_q, nib_cnt_d;
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tx_can;
    logic            msg_ready;
    logic [4:0]      hex;

    // Returns {is_hex, nibble} for one ASCII character.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [7:0] t;
        if (c >= 8'h30 && c <= 8'h39) begin
            t = c - 8'h30;
            return {1'b1, t[3:0]};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            t = c - 8'h57;
            return {1'b1, t[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            t = c - 8'h37;
            return {1'b1, t[3:0]};
        end
        return 5'b0;
    endfunction

    // TX may only fire when the core is idle and the pulse/guard window after
    // the previous tx_start has passed (busy lags tx_start in the core).
    assign tx_can = !bus.tx_busy && !tx_start_q && !guard_q;
    assign hex    = hex_decode(bus.rx_data);

    // Next-state and datapath updates for the job sequence.
    always_comb begin
        state_d     = state_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        digest_d    = digest_q;
        err_d       = err_q;
        trunc_d     = trunc_q;
        term_sent_d = term_sent_q;
        nib_cnt_d   = nib_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        msg_ready   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d     = StSendCmd;
                    digest_d    = '0;
                    err_d       = 2'd0;
                    trunc_d     = 1'b0;
                    term_sent_d = 1'b0;
                    nib_cnt_d   = '0;
                    tmo_cnt_d   = '0;
                end
            end
            StSendCmd: begin
                if (tx_can) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = START_BYTE;
                    state_d    = StSendMsg;
                end
            end
            StSendMsg: begin
                msg_ready = tx_can;
                if (bus.msg_valid && tx_can) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = bus.msg_data;
                    // An in-message terminator ends the frame early; the device
                    // starts hashing there, so stop accepting bytes.
                    if (bus.msg_data == TERM_BYTE && !bus.msg_last) begin
                        trunc_d = 1'b1;
                        state_d = StRecv;
                    end else if (bus.msg_last) begin
                        state_d = StSendTerm;
                    end
                end
            end
            StSendTerm: begin
                if (!term_sent_q) begin
                    if (tx_can) begin
                        tx_start_d  = 1'b1;
                        tx_data_d   = TERM_BYTE;
                        term_sent_d = 1'b1;
                    end
                end else if (tx_can) begin
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (bus.rx_valid) begin
                    tmo_cnt_d = '0;
                    if (hex[4]) begin
                        digest_d  = {digest_q[251:0], hex[3:0]};
                        nib_cnt_d = nib_cnt_q + 7'd1;
                        if (nib_cnt_q == 7'd63) begin
                            state_d = StFinish;
                        end
                    end else begin
                        err_d   = 2'd1;
                        state_d = StFinish;
                    end
                end else if (tmo_cnt_q == TmoLast) begin
                    err_d   = 2'd2;
                    state_d = StFinish;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tx_start_q  <= 1'b0;
            guard_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            digest_q    <= '0;
            err_q       <= 2'd0;
            trunc_q     <= 1'b0;
            term_sent_q <= 1'b0;
            nib_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_start_q  <= tx_start_d;
            guard_q     <= tx_start_q;
            tx_data_q   <= tx_data_d;
            digest_q    <= digest_d;
            err_q       <= err_d;
            trunc_q     <= trunc_d;
            term_sent_q <= term_sent_d;
            nib_cnt_q   <= nib_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.msg_ready = msg_ready;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StFinish);
    assign bus.digest    = digest_q;
    assign bus.err       = err_q;
    assign bus.trunc     = trunc_q;

endmodule
